regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (wr_addr0/wr_din0/we0) between two writeback requesters: req0 (ALU writeback) and req1 (load/long-latency unit).
- Uses valid/ready handshakes and round-robin arbitration.
- Registers the winning write for one cycle before it drives the regfile.
- Filters writes to x0 and counts arbitration stalls for performance debug.

---
 rtl/regfile_wb_arbiter.sv | 74 +++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between the ALU
// and load writeback paths; registers the winning write and counts stalls.
module regfile_wb_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int CNT_W = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [AW-1:0]    req0_addr,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [AW-1:0]    req1_addr,
   input  logic [WIDTH-1:0] req1_data,
   output logic             we0,
   output logic [AW-1:0]    wr_addr0,
   output logic [WIDTH-1:0] wr_din0,
   output logic             last_grant,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] STALL_MAX = '1;

   logic grant0;
   logic grant1;
   logic stall;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst) begin
         if (req0_valid && (!req1_valid || last_grant))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign stall      = (req0_valid && !grant0) || (req1_valid && !grant1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         we0        <= 1'b0;
         wr_addr0   <= '0;
         wr_din0    <= '0;
         last_grant <= 1'b1;
         stall_cnt  <= '0;
      end else begin
         we0 <= 1'b0;
         // x0 writes complete the handshake but never reach the regfile.
         if (grant0) begin
            we0        <= (req0_addr != '0);
            wr_addr0   <= req0_addr;
            wr_din0    <= req0_data;
            last_grant <= 1'b0;
         end else if (grant1) begin
            we0        <= (req1_addr != '0);
            wr_addr0   <= req1_addr;
            wr_din0    <= req1_data;
            last_grant <= 1'b1;
         end
         if (stall && (stall_cnt != STALL_MAX))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with hand-written expected readies,
// write-stage scoreboard, regfile model and reset/saturation sequences.
module tb_regfile_wb_arbiter;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int CNT_W = 4;
   localparam int AW    = 5;
   localparam int SMAX  = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic [AW-1:0]    req0_addr = '0, req1_addr = '0;
   logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
   logic             we0;
   logic [AW-1:0]    wr_addr0;
   logic [WIDTH-1:0] wr_din0;
   logic             last_grant;
   logic [CNT_W-1:0] stall_cnt;

   regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
      .last_grant(last_grant), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             v0;
      logic [AW-1:0]    a0;
      logic [WIDTH-1:0] d0;
      logic             v1;
      logic [AW-1:0]    a1;
      logic [WIDTH-1:0] d1;
      logic             er0;
      logic             er1;
   } vec_t;

   typedef struct {
      logic             we;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } wr_t;

   int n_tests = 0;
   int n_fail  = 0;

   wr_t              sb[$];
   logic [AW-1:0]    exp_addr;
   logic [WIDTH-1:0] exp_din;
   logic             exp_lg;
   int               exp_stall;
   logic [WIDTH-1:0] rf [DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      exp_addr  = '0;
      exp_din   = '0;
      exp_lg    = 1'b1;
      exp_stall = 0;
   endtask

   // Hold reset two cycles with both requesters asserting valid.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h9999_9999;
      req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAAAA_AAAA;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
         chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
         @(posedge clk); #1;
         chk("rst_we0", {31'b0, we0}, 32'd0);
         chk("rst_wr_addr0", {27'b0, wr_addr0}, 32'd0);
         chk("rst_wr_din0", wr_din0, 32'd0);
         chk("rst_last_grant", {31'b0, last_grant}, 32'd1);
         chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
         @(negedge clk);
      end
      model_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic cycle(input vec_t v, input string tag);
      wr_t e, got;
      @(negedge clk);
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
      #1;
      chk({tag, "_ready0"}, {31'b0, req0_ready}, {31'b0, v.er0});
      chk({tag, "_ready1"}, {31'b0, req1_ready}, {31'b0, v.er1});
      if (v.er0) begin
         exp_addr = v.a0; exp_din = v.d0; exp_lg = 1'b0;
         e = '{we: (v.a0 != 0), addr: v.a0, data: v.d0};
      end else if (v.er1) begin
         exp_addr = v.a1; exp_din = v.d1; exp_lg = 1'b1;
         e = '{we: (v.a1 != 0), addr: v.a1, data: v.d1};
      end else begin
         e = '{we: 1'b0, addr: exp_addr, data: exp_din};
      end
      if (((v.v0 && !v.er0) || (v.v1 && !v.er1)) && exp_stall < SMAX)
         exp_stall++;
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         chk({tag, "_we0"}, {31'b0, we0}, {31'b0, got.we});
         chk({tag, "_wr_addr0"}, {27'b0, wr_addr0}, {27'b0, got.addr});
         chk({tag, "_wr_din0"}, wr_din0, got.data);
      end
      chk({tag, "_last_grant"}, {31'b0, last_grant}, {31'b0, exp_lg});
      chk({tag, "_stall_cnt"}, {28'b0, stall_cnt}, exp_stall);
      if (we0) rf[wr_addr0] = wr_din0;
   endtask

   vec_t tbl[16];
   vec_t sv;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) rf[i] = '0;
      //            v0  a0  d0             v1  a1  d1             r0 r1
      tbl[0]  = '{1, 1, 32'h0000_1111, 1, 2, 32'h0000_2222, 1, 0};
      tbl[1]  = '{0, 0, 32'h0,         1, 2, 32'h0000_2222, 0, 1};
      tbl[2]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0};
      tbl[3]  = '{1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 0};
      tbl[4]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0};
      tbl[5]  = '{0, 0, 32'h0,         1, 0, 32'h1234_5678, 0, 1};
      tbl[6]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0};
      tbl[7]  = '{1, 1, 32'hA1A1_0001, 1, 3, 32'hB3B3_0003, 1, 0};
      tbl[8]  = '{1, 2, 32'hA2A2_0002, 1, 3, 32'hB3B3_0003, 0, 1};
      tbl[9]  = '{1, 2, 32'hA2A2_0002, 1, 4, 32'hB4B4_0004, 1, 0};
      tbl[10] = '{0, 0, 32'h0,         1, 4, 32'hB4B4_0004, 0, 1};
      tbl[11] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0};
      tbl[12] = '{1, 7, 32'hAAAA_0000, 1, 7, 32'h0000_BBBB, 1, 0};
      tbl[13] = '{0, 0, 32'h0,         1, 7, 32'h0000_BBBB, 0, 1};
      tbl[14] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0};
      tbl[15] = '{1, 0, 32'hFFFF_FFFF, 0, 0, 32'h0,         1, 0};

      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      for (int i = 0; i < 16; i++) cycle(tbl[i], $sformatf("vec%0d", i));
      chk("rf_reg7_conflict", rf[7], 32'h0000_BBBB);
      chk("rf_reg5_single", rf[5], 32'hDEAD_BEEF);
      chk("rf_reg0_filtered", rf[0], 32'h0);
      chk("rf_reg4_rr", rf[4], 32'hB4B4_0004);

      // Both requesters held valid: grants alternate and the counter saturates.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         sv = '{1, 5'd11, 32'h0000_0B00 + i, 1, 5'd12, 32'h0000_0C00 + i,
                (i % 2 == 0), (i % 2 == 1)};
         cycle(sv, $sformatf("sat%0d", i));
         if (i == 14) chk("sat_reach15", {28'b0, stall_cnt}, 32'd15);
      end
      chk("sat_hold15", {28'b0, stall_cnt}, 32'd15);

      // A write registered just before reset must be dropped at the reset edge.
      do_reset();
      sv = '{1, 5'd9, 32'h5555_AAAA, 0, 0, 32'h0, 1, 0};
      cycle(sv, "midrst_accept");
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd13; req0_data = 32'h1313_1313;
      #1;
      chk("midrst_ready0", {31'b0, req0_ready}, 32'd0);
      @(posedge clk); #1;
      chk("midrst_we0", {31'b0, we0}, 32'd0);
      chk("midrst_wr_addr0", {27'b0, wr_addr0}, 32'd0);
      chk("midrst_last_grant", {31'b0, last_grant}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      model_reset();
      sv = '{1, 5'd13, 32'h1313_1313, 1, 5'd14, 32'h1414_1414, 1, 0};
      cycle(sv, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
